// File: rtl/text_overlay_engine.sv
// +------------------------------------------------------------------------+
// | text_overlay_engine: two-stage top/bottom text banner overlay fed by   |
// | synchronous row ROMs, with frame-latched message, blink and scroll.    |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
`default_nettype none

module text_overlay_engine #(
  parameter int TEXT_W       = 210,
  parameter int TOP_H        = 25,
  parameter int BOT_H        = 15,
  parameter int MSG_COUNT    = 9,
  parameter int TOP_X        = 214,
  parameter int TOP_Y        = 0,
  parameter int BOT_X        = 214,
  parameter int BOT_Y        = 465,
  parameter int H_LAST       = 799,
  parameter int V_LAST       = 524,
  parameter int BLINK_FRAMES = 30
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 pix_tick,
  input  logic [9:0]                           HCount,
  input  logic [9:0]                           VCount,
  input  logic [MSG_COUNT-2:0]                 msg_sel,
  input  logic                                 blink_en,
  input  logic                                 scroll_en,
  output logic [$clog2(TOP_H)-1:0]             top_rom_addr,
  input  logic [TEXT_W-1:0]                    top_rom_data,
  output logic [$clog2(MSG_COUNT*BOT_H)-1:0]   bot_rom_addr,
  input  logic [TEXT_W-1:0]                    bot_rom_data,
  output logic                                 text_top_on,
  output logic                                 text_bottom_on,
  output logic [$clog2(MSG_COUNT)-1:0]         msg_idx
);

  localparam int c_top_aw = $clog2(TOP_H);
  localparam int c_bot_aw = $clog2(MSG_COUNT*BOT_H);
  localparam int c_idx_w  = $clog2(MSG_COUNT);
  localparam int c_col_w  = $clog2(TEXT_W);
  localparam int c_sum_w  = c_col_w + 1;
  localparam int c_blk_w  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  // Frame state
  logic                w_fb;
  logic [c_idx_w-1:0]  w_sel;
  logic                w_blk_wrap;
  logic [c_idx_w-1:0]  r_msg_idx;
  logic [c_col_w-1:0]  r_off;
  logic [c_blk_w-1:0]  r_blk_cnt;
  logic                r_phase;

  assign w_fb       = pix_tick && (HCount == 10'(H_LAST)) && (VCount == 10'(V_LAST));
  assign w_blk_wrap = (r_blk_cnt == c_blk_w'(BLINK_FRAMES-1));

  // Lowest set bit wins; scanning downward lets the lowest overwrite last.
  always_comb begin
    w_sel = c_idx_w'(MSG_COUNT-1);
    for (int i = MSG_COUNT-2; i >= 0; i--) begin
      if (msg_sel[i]) w_sel = c_idx_w'(i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_msg_idx <= c_idx_w'(MSG_COUNT-1);
      r_off     <= '0;
      r_blk_cnt <= '0;
    end else if (w_fb) begin
      r_msg_idx <= w_sel;
      if (w_sel != r_msg_idx)
        r_off <= '0;
      else if (scroll_en)
        r_off <= (r_off == c_col_w'(TEXT_W-1)) ? '0 : r_off + 1'b1;
      r_blk_cnt <= w_blk_wrap ? '0 : r_blk_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_phase <= 1'b0;
    else if (!blink_en)
      r_phase <= 1'b0;
    else if (w_fb && w_blk_wrap)
      r_phase <= ~r_phase;
  end

  // Stage 1: windows, columns, ROM addresses. Offsets wrap below the
  // origin so a single unsigned compare covers both window edges.
  logic [9:0]          w_top_dx, w_top_dy, w_bot_dx, w_bot_dy;
  logic                w_top_win, w_bot_win;
  logic [c_sum_w-1:0]  w_bot_sum;
  logic [c_col_w-1:0]  w_bot_col;
  logic [c_bot_aw-1:0] w_bot_addr;

  assign w_top_dx  = HCount - 10'(TOP_X);
  assign w_top_dy  = VCount - 10'(TOP_Y);
  assign w_bot_dx  = HCount - 10'(BOT_X);
  assign w_bot_dy  = VCount - 10'(BOT_Y);
  assign w_top_win = (w_top_dx < 10'(TEXT_W)) && (w_top_dy < 10'(TOP_H));
  assign w_bot_win = (w_bot_dx < 10'(TEXT_W)) && (w_bot_dy < 10'(BOT_H));

  assign w_bot_sum  = {1'b0, w_bot_dx[c_col_w-1:0]} + {1'b0, r_off};
  assign w_bot_col  = (w_bot_sum >= c_sum_w'(TEXT_W))
                      ? c_col_w'(w_bot_sum - c_sum_w'(TEXT_W))
                      : w_bot_sum[c_col_w-1:0];
  assign w_bot_addr = c_bot_aw'(r_msg_idx) * c_bot_aw'(BOT_H) + c_bot_aw'(w_bot_dy);

  logic                r_top_win, r_bot_win;
  logic [c_col_w-1:0]  r_top_col, r_bot_col;
  logic [c_top_aw-1:0] r_top_addr;
  logic [c_bot_aw-1:0] r_bot_addr;

  // Columns are zeroed outside the window so ROM indexing stays in range.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_top_win  <= 1'b0;
      r_bot_win  <= 1'b0;
      r_top_col  <= '0;
      r_bot_col  <= '0;
      r_top_addr <= '0;
      r_bot_addr <= '0;
    end else if (pix_tick) begin
      r_top_win  <= w_top_win;
      r_bot_win  <= w_bot_win;
      r_top_col  <= w_top_win ? w_top_dx[c_col_w-1:0] : '0;
      r_bot_col  <= w_bot_win ? w_bot_col : '0;
      r_top_addr <= w_top_win ? c_top_aw'(w_top_dy) : '0;
      r_bot_addr <= w_bot_win ? w_bot_addr : '0;
    end
  end

  // Stage 2: ROM data has settled one clk after stage 1.
  logic r_top_on, r_bot_on;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_top_on <= 1'b0;
      r_bot_on <= 1'b0;
    end else if (pix_tick) begin
      r_top_on <= r_top_win & top_rom_data[r_top_col];
      r_bot_on <= r_bot_win & bot_rom_data[r_bot_col] & ~r_phase;
    end
  end

  assign top_rom_addr   = r_top_addr;
  assign bot_rom_addr   = r_bot_addr;
  assign text_top_on    = r_top_on;
  assign text_bottom_on = r_bot_on;
  assign msg_idx        = r_msg_idx;

endmodule

`default_nettype wire

// File: tb/tb_text_overlay_engine.sv
// +------------------------------------------------------------------------+
// | tb_text_overlay_engine: directed bench with ROM models for the banner  |
// | overlay. Revision: 1.0                                                 |
// +------------------------------------------------------------------------+
`default_nettype none

module tb_text_overlay_engine;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         pix_tick = 1'b0;
  logic [9:0]   HCount = '0;
  logic [9:0]   VCount = '0;
  logic [7:0]   msg_sel = '0;
  logic         blink_en = 1'b0;
  logic         scroll_en = 1'b0;
  logic [4:0]   top_rom_addr;
  logic [209:0] top_rom_data = '0;
  logic [7:0]   bot_rom_addr;
  logic [209:0] bot_rom_data = '0;
  logic         text_top_on;
  logic         text_bottom_on;
  logic [3:0]   msg_idx;

  text_overlay_engine dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pix_tick       (pix_tick),
    .HCount         (HCount),
    .VCount         (VCount),
    .msg_sel        (msg_sel),
    .blink_en       (blink_en),
    .scroll_en      (scroll_en),
    .top_rom_addr   (top_rom_addr),
    .top_rom_data   (top_rom_data),
    .bot_rom_addr   (bot_rom_addr),
    .bot_rom_data   (bot_rom_data),
    .text_top_on    (text_top_on),
    .text_bottom_on (text_bottom_on),
    .msg_idx        (msg_idx)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int exp_off = 0;
  int exp_msg = 8;
  int exp_cnt = 0;
  bit exp_phase = 1'b0;
  bit rom_ones = 1'b0;

  function automatic logic tbit(int a, int c);
    return ((a*5 + c*3) % 7) < 3;
  endfunction

  function automatic logic bbit(int a, int c);
    return ((a*3 + c*7) % 11) < 5;
  endfunction

  // Synchronous ROM models: data follows the address one clock later.
  always @(posedge clk) begin
    logic [209:0] t, b;
    for (int i = 0; i < 210; i++) begin
      t[i] = rom_ones | tbit(int'(top_rom_addr), i);
      b[i] = rom_ones | bbit(int'(bot_rom_addr), i);
    end
    top_rom_data <= t;
    bot_rom_data <= b;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic bit top_win(int h, int v);
    return h >= 214 && h <= 423 && v >= 0 && v <= 24;
  endfunction

  function automatic bit bot_win(int h, int v);
    return h >= 214 && h <= 423 && v >= 465 && v <= 479;
  endfunction

  function automatic int sel_of(logic [7:0] s);
    for (int i = 0; i < 8; i++) if (s[i]) return i;
    return 8;
  endfunction

  task automatic tick(input int h, input int v);
    HCount   = 10'(h);
    VCount   = 10'(v);
    pix_tick = 1'b1;
    @(posedge clk); #1;
    pix_tick = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic fb();
    int ns;
    tick(799, 524);
    ns = sel_of(msg_sel);
    if (ns != exp_msg) begin
      exp_msg = ns;
      exp_off = 0;
    end else if (scroll_en) begin
      exp_off = (exp_off + 1) % 210;
    end
    if (exp_cnt == 29) begin
      exp_cnt   = 0;
      exp_phase = blink_en ? !exp_phase : 1'b0;
    end else begin
      exp_cnt++;
    end
    if (!blink_en) exp_phase = 1'b0;
  endtask

  task automatic model_reset();
    exp_off = 0; exp_msg = 8; exp_cnt = 0; exp_phase = 1'b0;
  endtask

  // Present one pixel, check its ROM addresses, then its on-flags two ticks later.
  task automatic px(input string tag, input int h, input int v);
    int tcol, bcol, brow;
    logic et, eb;
    tcol = h - 214;
    bcol = (h - 214 + exp_off) % 210;
    brow = exp_msg*15 + (v - 465);
    tick(h, v);
    chk({tag, "_taddr"}, 32'(top_rom_addr), top_win(h, v) ? 32'(v) : 32'd0);
    chk({tag, "_baddr"}, 32'(bot_rom_addr), bot_win(h, v) ? 32'(brow) : 32'd0);
    et = top_win(h, v) && (rom_ones || tbit(v, tcol));
    eb = bot_win(h, v) && (rom_ones || bbit(brow, bcol)) && !exp_phase;
    tick(0, 100);
    chk({tag, "_top"}, 32'(text_top_on), 32'(et));
    chk({tag, "_bot"}, 32'(text_bottom_on), 32'(eb));
  endtask

  initial begin
    rst_n = 1'b0;
    #12;
    chk("rst_top_on", 32'(text_top_on), 32'd0);
    chk("rst_bot_on", 32'(text_bottom_on), 32'd0);
    chk("rst_taddr", 32'(top_rom_addr), 32'd0);
    chk("rst_baddr", 32'(bot_rom_addr), 32'd0);
    chk("rst_msg_idx", 32'(msg_idx), 32'd8);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Default message 8: bottom row 0 is ROM row 120.
    px("b_origin", 214, 465);
    px("t_origin", 214, 0);
    px("t_corner", 423, 24);
    fb();
    chk("msg_none", 32'(msg_idx), 32'd8);

    // Window edges with an all-ones ROM so in-window pixels read 1.
    rom_ones = 1'b1;
    px("t_left", 213, 0);
    px("t_right", 424, 0);
    px("t_below", 214, 25);
    px("t_in", 214, 0);
    px("b_left", 213, 465);
    px("b_right", 424, 465);
    px("b_below", 214, 480);
    px("b_in", 423, 479);
    rom_ones = 1'b0;

    // Mid-frame select takes effect only at the frame boundary.
    msg_sel = 8'b0000_0110;
    px("sel_mid", 300, 470);
    chk("msg_hold", 32'(msg_idx), 32'd8);
    fb();
    chk("msg_latch", 32'(msg_idx), 32'd1);
    px("sel_new", 214, 465);

    // Scroll: 5, then 209, then wrap to 0 on the 210th frame.
    scroll_en = 1'b1;
    repeat (5) fb();
    px("off5_a", 214, 465);
    px("off5_b", 300, 470);
    repeat (204) fb();
    px("off209_a", 215, 465);
    px("off209_b", 214, 465);
    fb();
    px("off_wrap", 214, 465);
    px("off_wrap_b", 400, 477);

    // Message change while scrolling forces offset 0.
    fb();
    fb();
    msg_sel = 8'b0000_0001;
    fb();
    chk("msg_chg", 32'(msg_idx), 32'd0);
    px("chg_off0", 250, 470);

    // Asynchronous reset in the middle of a line.
    rom_ones = 1'b1;
    px("pre_rst", 214, 465);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("arst_top_on", 32'(text_top_on), 32'd0);
    chk("arst_bot_on", 32'(text_bottom_on), 32'd0);
    chk("arst_msg_idx", 32'(msg_idx), 32'd8);
    model_reset();
    rom_ones = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    px("post_rst_b", 260, 466);
    px("post_rst_t", 300, 10);

    // Blink from a fresh counter: frames 30..59 blanked on the bottom only.
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    msg_sel   = 8'b0000_0000;
    scroll_en = 1'b0;
    blink_en  = 1'b1;
    rom_ones  = 1'b1;
    for (int f = 0; f < 90; f++) begin
      tick(214, 465);
      tick(214, 0);
      chk($sformatf("blink_bot_f%0d", f), 32'(text_bottom_on),
          (f < 30 || f >= 60) ? 32'd1 : 32'd0);
      tick(0, 100);
      chk($sformatf("blink_top_f%0d", f), 32'(text_top_on), 32'd1);
      fb();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
